// File: rtl/d2_hazard_ctrl.sv
// d2_hazard_ctrl
//   Issue/hazard control for the D1->D2 decode register. Tracks in-flight GPR
//   writers in EX/M1/M2 (scoreboard slots), resolves D2's sources against them
//   into forwarding selects or a stall, sequences restart flushes and counts
//   stall cycles with saturation.
module d2_hazard_ctrl #(
  parameter int DEPTH = 3,  // scoreboard slots after D2 (slot0=EX), 2..4
  parameter int CNT_W = 16  // stall-cycle counter width
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             D2_Valid,
  input  logic [4:0]       D2_Rs,
  input  logic [4:0]       D2_Rt,
  input  logic             D2_UsesRs,
  input  logic             D2_UsesRt,
  input  logic             D2_WrEn,
  input  logic [4:0]       D2_Dest,
  input  logic [1:0]       D2_RdyAt,
  input  logic             EX_Stall,
  input  logic             Flush_Req,
  output logic             D2_Stall,
  output logic             D2_Flush,
  output logic             D2_Issue,
  output logic [1:0]       D2_FwdSelA,
  output logic [1:0]       D2_FwdSelB,
  output logic [CNT_W-1:0] Stall_Count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HAZ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t stateReg, stateNext;

  // Scoreboard slots: {valid, dest, rdyAt}; index 0 is the youngest (EX).
  logic [DEPTH-1:0]      slotValidReg, slotValidNext;
  logic [DEPTH-1:0][4:0] slotDestReg,  slotDestNext;
  logic [DEPTH-1:0][1:0] slotRdyReg,   slotRdyNext;

  logic [DEPTH-1:0] matchA;
  logic [DEPTH-1:0] matchB;
  logic [DEPTH-1:0] readyHere;
  logic             inFlush;
  logic             hazA;
  logic             hazB;
  logic             hazard;
  logic [1:0]       selA;
  logic [1:0]       selB;
  logic [CNT_W-1:0] stallCountReg;

  assign inFlush = (stateReg == FLUSH);

  // Per-slot comparators. r0 is hard-wired zero, so a write to it never matches.
  // readyHere[k]: a producer sitting in slot k already has its result available.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gSlotCmp
      assign matchA[gi]    = slotValidReg[gi] && (slotDestReg[gi] == D2_Rs) && (D2_Rs != 5'd0);
      assign matchB[gi]    = slotValidReg[gi] && (slotDestReg[gi] == D2_Rt) && (D2_Rt != 5'd0);
      assign readyHere[gi] = ({1'b0, slotRdyReg[gi]} <= 3'(gi));
    end
  endgenerate

  // Returns {hazard, fwdSel}. The lowest-index (youngest) match overrides older
  // ones, so the loop walks from oldest to youngest and the last hit wins.
  // With DEPTH=4 the slot-3 select wraps to 0: by then the write has reached
  // the regfile, which is assumed write-through.
  function automatic logic [2:0] pickSource(
    input logic             uses,
    input logic [DEPTH-1:0] match,
    input logic [DEPTH-1:0] ready
  );
    logic [2:0] res;
    res = 3'b000;
    if (uses) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (match[k]) begin
          res = ready[k] ? {1'b0, 2'(k + 1)} : 3'b100;
        end
      end
    end
    return res;
  endfunction

  // Resolve both D2 sources against the scoreboard
  always_comb begin
    {hazA, selA} = pickSource(D2_UsesRs, matchA, readyHere);
    {hazB, selB} = pickSource(D2_UsesRt, matchB, readyHere);
  end

  assign hazard     = D2_Valid && (hazA || hazB);
  // A flush cycle squashes D2, so holding it would be pointless.
  assign D2_Stall   = !inFlush && (EX_Stall || hazard);
  assign D2_Issue   = D2_Valid && !D2_Stall && !inFlush;
  assign D2_Flush   = inFlush;
  assign D2_FwdSelA = selA;
  assign D2_FwdSelB = selB;
  assign Stall_Count = stallCountReg;

  // Shift network: slot0 takes the issuing instruction (or a bubble), others
  // take their younger neighbour; the oldest slot simply retires.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gSlotShift
      if (gi == 0) begin : gHead
        assign slotValidNext[gi] = D2_Issue && D2_WrEn;
        assign slotDestNext[gi]  = D2_Dest;
        assign slotRdyNext[gi]   = D2_RdyAt;
      end else begin : gTail
        assign slotValidNext[gi] = slotValidReg[gi-1];
        assign slotDestNext[gi]  = slotDestReg[gi-1];
        assign slotRdyNext[gi]   = slotRdyReg[gi-1];
      end
    end
  endgenerate

  // Slot valid bits: flush clears, downstream stall freezes, otherwise advance
  always_ff @(posedge clock) begin
    if (reset || Flush_Req || inFlush) begin
      slotValidReg <= '0;
    end else if (!EX_Stall) begin
      slotValidReg <= slotValidNext;
    end
  end

  // Slot payload follows the same advance/freeze rule; contents of invalid slots are don't-care
  always_ff @(posedge clock) begin
    if (reset) begin
      slotDestReg <= '0;
      slotRdyReg  <= '0;
    end else if (!EX_Stall) begin
      slotDestReg <= slotDestNext;
      slotRdyReg  <= slotRdyNext;
    end
  end

  // Control state register
  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg <= RUN;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state: a flush request wins over everything; FLUSH lasts one cycle
  // unless another request arrives during it.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RUN: begin
        if (Flush_Req) begin
          stateNext = FLUSH;
        end else if (hazard && !EX_Stall) begin
          stateNext = HAZ;
        end
      end
      HAZ: begin
        if (Flush_Req) begin
          stateNext = FLUSH;
        end else if (!hazard) begin
          stateNext = RUN;
        end
      end
      FLUSH: begin
        stateNext = Flush_Req ? FLUSH : RUN;
      end
      default: begin
        stateNext = RUN;
      end
    endcase
  end

  // Saturating stall-cycle counter for the perf block
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCountReg <= '0;
    end else if (D2_Stall && (stallCountReg != {CNT_W{1'b1}})) begin
      stallCountReg <= stallCountReg + CNT_W'(1);
    end
  end

endmodule
